// File: rtl/lib_cpu.sv
// Shared CPU types: execute-stage result record, commit-stage state, default sizes.
package lib_cpu;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned NREG_DEFAULT      = 16;
  localparam int unsigned MEM_WORDS_DEFAULT = 64;
  localparam int unsigned MEM_ADDR_W        = 6;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic                  w_rd;
    logic [XLEN-1:0]       x_rd;
    logic                  mem_w_req;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]       mem_val;
    logic                  intr_en;
    logic [XLEN-1:0]       intr_pc;
    logic [XLEN-1:0]       intr_vec;
    logic                  ack;
    logic                  w_req;
    logic [7:0]            w_data;
  } EXECUTE;

  typedef enum logic {
    RUN     = 1'b0,
    TX_WAIT = 1'b1
  } COMMIT_STATE;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register array; x0 reads as zero and is never written.
module regfile_2r1w
  import lib_cpu::*;
#(
  parameter int unsigned NREG  = NREG_DEFAULT,
  parameter int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [IDX_W-1:0] raddr1_i,
  input  logic [IDX_W-1:0] raddr2_i,
  output logic [XLEN-1:0]  rdata1_o,
  output logic [XLEN-1:0]  rdata2_o
);

  logic [XLEN-1:0] rf_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-write value in the write cycle (no bypass).
  assign rdata1_o = (raddr1_i == '0) ? '0 : rf_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : rf_q[raddr2_i];

endmodule

// File: rtl/cpu_commit.sv
// Architectural-state commit stage: PC, regfile, data memory, interrupt SRs,
// UART transmit request with stall until the byte is accepted.
module cpu_commit
  import lib_cpu::*;
#(
  parameter int unsigned NREG      = NREG_DEFAULT,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int unsigned IDX_W     = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  EXECUTE                ex,
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [IDX_W-1:0]      rs1_idx,
  input  logic [IDX_W-1:0]      rs2_idx,
  output logic [XLEN-1:0]       x_rs1,
  output logic [XLEN-1:0]       x_rs2,
  input  logic [MEM_ADDR_W-1:0] mem_rd_addr,
  output logic [XLEN-1:0]       mem_rd_data,
  output logic [XLEN-1:0]       pc,
  output logic                  intr_en,
  output logic [XLEN-1:0]       intr_pc,
  output logic [XLEN-1:0]       intr_vec,
  output logic                  w_busy,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  intr_ack
);

  COMMIT_STATE     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            intr_en_q, intr_en_d;
  logic [XLEN-1:0] intr_pc_q, intr_pc_d;
  logic [XLEN-1:0] intr_vec_q, intr_vec_d;
  logic            intr_ack_q, intr_ack_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            rf_we_c;
  logic            mem_we_c;
  logic [XLEN-1:0] mem_q [MEM_WORDS];

  // Next-state and commit decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    intr_en_d  = intr_en_q;
    intr_pc_d  = intr_pc_q;
    intr_vec_d = intr_vec_q;
    intr_ack_d = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    rf_we_c    = 1'b0;
    mem_we_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_valid) begin
          pc_d       = ex.pc;
          intr_en_d  = ex.intr_en;
          intr_pc_d  = ex.intr_pc;
          intr_vec_d = ex.intr_vec;
          intr_ack_d = ex.ack;
          rf_we_c    = ex.w_rd;
          mem_we_c   = ex.mem_w_req;
          if (ex.w_req) begin
            tx_data_d  = ex.w_data;
            tx_valid_d = 1'b1;
            state_d    = TX_WAIT;
          end
        end
      end
      TX_WAIT: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= '0;
      intr_en_q  <= 1'b0;
      intr_pc_q  <= '0;
      intr_vec_q <= '0;
      intr_ack_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      intr_en_q  <= intr_en_d;
      intr_pc_q  <= intr_pc_d;
      intr_vec_q <= intr_vec_d;
      intr_ack_q <= intr_ack_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Data memory held in flops so reset can clear every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[ex.mem_addr] <= ex.mem_val;
    end
  end

  regfile_2r1w #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we_c),
    .waddr_i  (rd_idx),
    .wdata_i  (ex.x_rd),
    .raddr1_i (rs1_idx),
    .raddr2_i (rs2_idx),
    .rdata1_o (x_rs1),
    .rdata2_o (x_rs2)
  );

  assign ex_ready    = (state_q == RUN);
  assign mem_rd_data = mem_q[mem_rd_addr];
  assign pc          = pc_q;
  assign intr_en     = intr_en_q;
  assign intr_pc     = intr_pc_q;
  assign intr_vec    = intr_vec_q;
  assign intr_ack    = intr_ack_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign w_busy      = tx_valid_q;

endmodule

// File: tb/tb_cpu_commit.sv
// Randomized bench for cpu_commit against a behavioural architectural-state model.
module tb_cpu_commit;
  import lib_cpu::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  EXECUTE      ex;
  logic [3:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] x_rs1, x_rs2;
  logic [5:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] pc;
  logic        intr_en;
  logic [31:0] intr_pc, intr_vec;
  logic        w_busy, tx_valid, tx_ready, intr_ack;
  logic [7:0]  tx_data;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference model of the architectural state
  logic [31:0] m_rf [16];
  logic [31:0] m_mem [64];
  logic [31:0] m_pc, m_ipc, m_ivec;
  logic        m_ien, m_ack, m_pending;
  logic [7:0]  m_txd;

  always #5 clk = ~clk;

  cpu_commit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex          (ex),
    .rd_idx      (rd_idx),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .x_rs1       (x_rs1),
    .x_rs2       (x_rs2),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .pc          (pc),
    .intr_en     (intr_en),
    .intr_pc     (intr_pc),
    .intr_vec    (intr_vec),
    .w_busy      (w_busy),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .intr_ack    (intr_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_pc = '0; m_ipc = '0; m_ivec = '0;
    m_ien = 1'b0; m_ack = 1'b0; m_pending = 1'b0; m_txd = '0;
  endtask

  // Architectural effect of one clock edge, given the inputs present at it.
  task automatic model_edge();
    m_ack = 1'b0;
    if (m_pending) begin
      if (tx_ready) m_pending = 1'b0;
    end else if (ex_valid) begin
      m_pc   = ex.pc;
      m_ien  = ex.intr_en;
      m_ipc  = ex.intr_pc;
      m_ivec = ex.intr_vec;
      m_ack  = ex.ack;
      if (ex.w_rd && rd_idx != 4'd0) m_rf[rd_idx] = ex.x_rd;
      if (ex.mem_w_req) m_mem[ex.mem_addr] = ex.mem_val;
      if (ex.w_req) begin
        m_txd     = ex.w_data;
        m_pending = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    check("pc",       pc,                  m_pc);
    check("x_rs1",    x_rs1,               m_rf[rs1_idx]);
    check("x_rs2",    x_rs2,               m_rf[rs2_idx]);
    check("mem_rd",   mem_rd_data,         m_mem[mem_rd_addr]);
    check("intr_en",  32'(intr_en),        32'(m_ien));
    check("intr_pc",  intr_pc,             m_ipc);
    check("intr_vec", intr_vec,            m_ivec);
    check("intr_ack", 32'(intr_ack),       32'(m_ack));
    check("tx_valid", 32'(tx_valid),       32'(m_pending));
    check("w_busy",   32'(w_busy),         32'(m_pending));
    check("tx_data",  32'(tx_data),        32'(m_txd));
    check("ex_ready", 32'(ex_ready),       32'(!m_pending));
  endtask

  // Inputs are set shortly after a rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex = '0; rd_idx = '0; tx_ready = 1'b0;
    rs1_idx = '0; rs2_idx = '0; mem_rd_addr = '0;
  endtask

  task automatic random_inputs();
    ex_valid     = ($urandom_range(0, 3) != 0);
    ex.pc        = $urandom;
    ex.w_rd      = $urandom_range(0, 1);
    ex.x_rd      = $urandom;
    ex.mem_w_req = $urandom_range(0, 1);
    ex.mem_addr  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 3));
    ex.mem_val   = $urandom;
    ex.intr_en   = $urandom_range(0, 1);
    ex.intr_pc   = $urandom;
    ex.intr_vec  = $urandom;
    ex.ack       = $urandom_range(0, 1);
    ex.w_req     = ($urandom_range(0, 4) == 0);
    ex.w_data    = 8'($urandom);
    rd_idx       = 4'($urandom);
    rs1_idx      = 4'($urandom);
    rs2_idx      = 4'($urandom);
    tx_ready     = $urandom_range(0, 1);
    mem_rd_addr  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 3));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #2;
    check_all();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Register write and PC update
    ex_valid = 1'b1; ex.pc = 32'd5; ex.w_rd = 1'b1; ex.x_rd = 32'hDEAD_BEEF; rd_idx = 4'd3;
    cycle();
    idle_inputs(); rs1_idx = 4'd3; #1;
    check("plan_pc", pc, 32'd5);
    check("plan_rf3", x_rs1, 32'hDEAD_BEEF);
    cycle();

    // Write to x0 is dropped
    ex_valid = 1'b1; ex.w_rd = 1'b1; ex.x_rd = 32'd7; rd_idx = 4'd0;
    cycle();
    idle_inputs(); #1;
    check("plan_x0", x_rs1, 32'd0);

    // Top memory word
    ex_valid = 1'b1; ex.mem_w_req = 1'b1; ex.mem_addr = 6'd63; ex.mem_val = 32'h1234;
    cycle();
    idle_inputs(); mem_rd_addr = 6'd63; #1;
    check("plan_mem63", mem_rd_data, 32'h1234);
    mem_rd_addr = 6'd0; #1;
    check("plan_mem0", mem_rd_data, 32'd0);

    // UART stall: tx_ready low for 3 cycles, second record must not commit
    ex_valid = 1'b1; ex.w_req = 1'b1; ex.w_data = 8'h41; ex.pc = 32'h44;
    cycle();
    ex = '0; ex_valid = 1'b1; ex.pc = 32'h99; ex.w_rd = 1'b1; ex.x_rd = 32'h55; rd_idx = 4'd4;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_txd", 32'(tx_data), 32'h41);
      check("stall_rdy", 32'(ex_ready), 32'd0);
      cycle();
    end
    tx_ready = 1'b1;
    cycle();
    ex_valid = 1'b0; tx_ready = 1'b0; rs1_idx = 4'd4; #1;
    check("stall_pc", pc, 32'h44);
    check("stall_rf4", x_rs1, 32'd0);
    check("stall_done", 32'(ex_ready), 32'd1);
    cycle();

    // Interrupt acknowledge pulse
    idle_inputs();
    ex_valid = 1'b1; ex.ack = 1'b1; ex.intr_en = 1'b0; ex.intr_pc = 32'd9; ex.intr_vec = 32'h100;
    cycle();
    idle_inputs(); #1;
    check("ack_pulse", 32'(intr_ack), 32'd1);
    cycle();
    check("ack_clear", 32'(intr_ack), 32'd0);
    check("ack_ipc", intr_pc, 32'd9);
    check("ack_ivec", intr_vec, 32'h100);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      random_inputs();
      cycle();
    end

    // Reset while a byte is pending
    idle_inputs();
    ex_valid = 1'b1; ex.w_req = 1'b1; ex.w_data = 8'h5A; ex.pc = 32'h123;
    cycle();
    idle_inputs();
    cycle();
    check("pre_rst_txv", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_pc", pc, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", 32'(ex_ready), 32'd1);
    for (int n = 0; n < 200; n++) begin
      random_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
